// File: rtl/rv_mul_pipeline_pkg.sv
// Shared ALU multiply definitions: op encodings and operand-signedness helpers
// used by the lane datapath and the pipeline top.
package rv_mul_pipeline_pkg;

  localparam int MUL_OP_BITS = 2;

  typedef enum logic [MUL_OP_BITS-1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  function automatic logic mul_op_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic mul_op_b_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

  function automatic logic mul_op_high(input mul_op_e op);
    return (op != MUL_OP_MUL);
  endfunction

endpackage

// File: rtl/rv_mul_lane.sv
// One multiply lane: operand extension, product and high/low half select.
// Purely combinational; the top registers its result in stage 0.
module rv_mul_lane
  import rv_mul_pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mul_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  logic                         a_sx;
  logic                         b_sx;
  logic signed [2*WIDTH-1:0]    a_wide;
  logic signed [2*WIDTH-1:0]    b_wide;
  logic signed [2*WIDTH-1:0]    prod;

  assign a_sx = mul_op_a_signed(op) & a[WIDTH-1];
  assign b_sx = mul_op_b_signed(op) & b[WIDTH-1];

  // Extending straight to 2*WIDTH gives the same low 2*WIDTH product bits as a
  // (WIDTH+1)x(WIDTH+1) signed multiply, without carrying unused upper bits.
  assign a_wide = $signed({{WIDTH{a_sx}}, a});
  assign b_wide = $signed({{WIDTH{b_sx}}, b});
  assign prod   = a_wide * b_wide;

  assign res = mul_op_high(op) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

endmodule

// File: rtl/rv_mul_pipeline.sv
// Multi-lane RV32M multiply unit with an elastic valid/ready register chain;
// stalled stages hold and empty stages collapse so upstream keeps moving.
module rv_mul_pipeline
  import rv_mul_pipeline_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int TAGW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [MUL_OP_BITS-1:0] op_in,
  input  logic [LANES*WIDTH-1:0] dataa_in,
  input  logic [LANES*WIDTH-1:0] datab_in,
  input  logic [TAGW-1:0]        tag_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [LANES*WIDTH-1:0] result_out,
  output logic [TAGW-1:0]        tag_out,
  output logic                   busy
);

  localparam int DW = LANES * WIDTH;

  logic [DW-1:0]      prod_res;
  logic               accept;
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] adv;
  logic [DW-1:0]      data_q [LATENCY];
  logic [TAGW-1:0]    tag_q  [LATENCY];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rv_mul_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .op  (mul_op_e'(op_in)),
      .a   (dataa_in[l*WIDTH +: WIDTH]),
      .b   (datab_in[l*WIDTH +: WIDTH]),
      .res (prod_res[l*WIDTH +: WIDTH])
    );
  end

  // Stage k may advance if it or any stage after it is empty, or the consumer
  // takes the head. Written flat so the chain has no self-referencing vector.
  always_comb begin
    adv = '0;
    for (int k = 0; k < LATENCY; k++) begin
      adv[k] = ready_out;
      for (int j = k; j < LATENCY; j++) begin
        adv[k] = adv[k] | ~v_q[j];
      end
    end
  end

  assign ready_in = adv[0];
  assign accept   = valid_in & ready_in;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic            v_prev;
    logic [DW-1:0]   d_prev;
    logic [TAGW-1:0] t_prev;
    logic            v_r;
    logic [DW-1:0]   d_r;
    logic [TAGW-1:0] t_r;

    if (k == 0) begin : g_head
      assign v_prev = accept;
      assign d_prev = prod_res;
      assign t_prev = tag_in;
    end else begin : g_body
      assign v_prev = v_q[k-1];
      assign d_prev = data_q[k-1];
      assign t_prev = tag_q[k-1];
    end

    // Payload only loads with a valid entry so idle outputs keep their last value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_r <= 1'b0;
        d_r <= '0;
        t_r <= '0;
      end else if (adv[k]) begin
        v_r <= v_prev;
        if (v_prev) begin
          d_r <= d_prev;
          t_r <= t_prev;
        end
      end
    end

    assign v_q[k]    = v_r;
    assign data_q[k] = d_r;
    assign tag_q[k]  = t_r;
  end

  assign valid_out  = v_q[LATENCY-1];
  assign result_out = data_q[LATENCY-1];
  assign tag_out    = tag_q[LATENCY-1];
  assign busy       = |v_q;

endmodule

// File: tb/tb_rv_mul_pipeline.sv
// Scoreboard bench for rv_mul_pipeline: a 64-bit reference model fills a queue
// on accept; a monitor pops and compares on every output handshake.
module tb_rv_mul_pipeline;
  import rv_mul_pipeline_pkg::*;

  localparam int LANES   = 4;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 3;
  localparam int TAGW    = 8;
  localparam int LW      = LANES * WIDTH;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [LW-1:0]   res;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid_in = 1'b0;
  logic            ready_in;
  logic [1:0]      op_in = 2'd0;
  logic [LW-1:0]   dataa_in = '0;
  logic [LW-1:0]   datab_in = '0;
  logic [TAGW-1:0] tag_in = '0;
  logic            valid_out;
  logic            ready_out = 1'b1;
  logic [LW-1:0]   result_out;
  logic [TAGW-1:0] tag_out;
  logic            busy;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t mon_e;

  rv_mul_pipeline #(
    .LANES(LANES), .WIDTH(WIDTH), .LATENCY(LATENCY), .TAGW(TAGW)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .op_in(op_in), .dataa_in(dataa_in), .datab_in(datab_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .result_out(result_out),
    .tag_out(tag_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_lane(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    logic [63:0]     p;
    case (op)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * longint'(ub);
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [LW-1:0] ref_vec(input logic [1:0] op, input logic [LW-1:0] a,
                                            input logic [LW-1:0] b);
    logic [LW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*32 +: 32] = ref_lane(op, a[l*32 +: 32], b[l*32 +: 32]);
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output monitor: sampled mid-low-phase, after the drivers' own checks.
  always begin
    @(negedge clk);
    #3;
    if (reset && valid_out && ready_out) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_extra: got tag=%0h res=%h, expected no output", tag_out, result_out);
      end else begin
        mon_e = q.pop_front();
        if (result_out !== mon_e.res || tag_out !== mon_e.tag) begin
          fails++;
          $display("FAIL scoreboard: got tag=%0h res=%h, expected tag=%0h res=%h",
                   tag_out, result_out, mon_e.tag, mon_e.res);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b,
                      input logic [TAGW-1:0] tg);
    int waited = 0;
    @(negedge clk);
    valid_in = 1'b1; op_in = op; dataa_in = a; datab_in = b; tag_in = tg;
    #2;
    while (!ready_in && waited < 50) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!ready_in) begin
      tests++; fails++;
      $display("FAIL send_timeout: ready_in=%b after %0d cycles, expected 1", ready_in, waited);
    end else begin
      q.push_back('{tag: tg, res: ref_vec(op, a, b)});
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready_out = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (valid_out !== 1'b0 || result_out !== '0 || tag_out !== '0 || busy !== 1'b0 || ready_in !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: valid=%b res=%h tag=%h busy=%b ready_in=%b, expected 0/0/0/0/1",
               valid_out, result_out, tag_out, busy, ready_in);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mul_latency();
    int i;
    ready_out = 1'b1;
    send(MUL_OP_MUL, {LANES{32'hFFFF_FFFF}}, {LANES{32'hFFFF_FFFF}}, 8'hA5);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_accept: busy=%b, expected 1", busy);
    end
    for (i = 1; i <= 20; i++) begin
      @(negedge clk);
      #2;
      if (valid_out) break;
    end
    tests++;
    if (i != LATENCY) begin
      fails++;
      $display("FAIL mul_latency: valid_out after %0d cycles, expected %0d", i, LATENCY);
    end
    tests++;
    if (result_out !== {LANES{32'h0000_0001}} || tag_out !== 8'hA5) begin
      fails++;
      $display("FAIL mul_ffff: res=%h tag=%h, expected all lanes 00000001 tag a5", result_out, tag_out);
    end
    drain();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_high_variants();
    logic [1:0]  ops  [5] = '{MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU, MUL_OP_MULH, MUL_OP_MUL};
    logic [31:0] opa  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] want [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'h0000_0000};
    for (int t = 0; t < 5; t++) begin
      int i;
      send(ops[t], {LANES{opa[t]}}, {LANES{opa[t]}}, TAGW'(8'h10 + t));
      for (i = 1; i <= 20; i++) begin
        @(negedge clk);
        #2;
        if (valid_out) break;
      end
      tests++;
      if (!valid_out || result_out !== {LANES{want[t]}} || tag_out !== TAGW'(8'h10 + t)) begin
        fails++;
        $display("FAIL corner_op%0d: valid=%b res=%h tag=%h, expected lanes %h tag %h",
                 ops[t], valid_out, result_out, tag_out, want[t], TAGW'(8'h10 + t));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [LW-1:0]   bp_a [8];
    logic [LW-1:0]   bp_b [8];
    logic [LW-1:0]   prev_res = '0;
    logic [TAGW-1:0] prev_tag = '0;
    logic            stall_prev = 1'b0;
    logic            exp_rdy;
    int              sent = 0, cyc = 0, low_seen = 0;
    for (int k = 0; k < 8; k++) begin
      bp_a[k] = rnd_vec();
      bp_b[k] = rnd_vec();
    end
    while ((sent < 8 || q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      ready_out = !(cyc >= 3 && cyc < 8);
      if (sent < 8) begin
        valid_in = 1'b1; op_in = 2'(sent % 4);
        dataa_in = bp_a[sent]; datab_in = bp_b[sent]; tag_in = TAGW'(sent);
      end else begin
        valid_in = 1'b0;
      end
      #2;
      exp_rdy = ready_out || (q.size() < LATENCY);
      tests++;
      if (ready_in !== exp_rdy) begin
        fails++;
        $display("FAIL bp_ready_in: cycle %0d ready_in=%b, expected %b (occupancy %0d)",
                 cyc, ready_in, exp_rdy, q.size());
      end
      if (!ready_in) low_seen++;
      if (stall_prev) begin
        tests++;
        if (valid_out !== 1'b1 || result_out !== prev_res || tag_out !== prev_tag) begin
          fails++;
          $display("FAIL bp_stable: cycle %0d valid=%b tag=%h res=%h, expected held tag=%h res=%h",
                   cyc, valid_out, tag_out, result_out, prev_tag, prev_res);
        end
      end
      stall_prev = valid_out && !ready_out;
      prev_res   = result_out;
      prev_tag   = tag_out;
      if (valid_in && ready_in) begin
        q.push_back('{tag: TAGW'(sent), res: ref_vec(op_in, dataa_in, datab_in)});
        sent++;
      end
      cyc++;
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    tests++;
    if (cyc >= 100 || low_seen == 0) begin
      fails++;
      $display("FAIL bp_progress: cycles=%0d sent=%0d ready_in_low_cycles=%0d, expected completion with a full stall",
               cyc, sent, low_seen);
    end
    drain();
  endtask

  task automatic test_bubble_collapse();
    logic [LW-1:0] a2;
    logic [LW-1:0] b2;
    ready_out = 1'b0;
    send(MUL_OP_MULHU, rnd_vec(), rnd_vec(), 8'hB0);
    repeat (LATENCY - 1) @(negedge clk);
    @(negedge clk);
    a2 = rnd_vec(); b2 = rnd_vec();
    valid_in = 1'b1; op_in = MUL_OP_MULHSU; dataa_in = a2; datab_in = b2; tag_in = 8'hB1;
    #2;
    tests++;
    if (ready_in !== 1'b1) begin
      fails++;
      $display("FAIL bubble_accept: ready_in=%b, expected 1 behind stalled head", ready_in);
    end else begin
      q.push_back('{tag: 8'hB1, res: ref_vec(MUL_OP_MULHSU, a2, b2)});
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (LATENCY) @(negedge clk);
    #2;
    tests++;
    if (valid_out !== 1'b1 || tag_out !== 8'hB0 || busy !== 1'b1 || ready_in !== (LATENCY > 2)) begin
      fails++;
      $display("FAIL bubble_hold: valid=%b tag=%h busy=%b ready_in=%b, expected 1/b0/1/%b",
               valid_out, tag_out, busy, ready_in, LATENCY > 2);
    end
    @(negedge clk);
    ready_out = 1'b1;
    #2;
    tests++;
    if (valid_out !== 1'b1 || tag_out !== 8'hB0) begin
      fails++;
      $display("FAIL bubble_pop_first: valid=%b tag=%h, expected 1/b0", valid_out, tag_out);
    end
    @(negedge clk);
    #2;
    tests++;
    if (valid_out !== 1'b1 || tag_out !== 8'hB1) begin
      fails++;
      $display("FAIL bubble_pop_second: valid=%b tag=%h, expected 1/b1 on next cycle", valid_out, tag_out);
    end
    drain();
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), TAGW'(8'h40 + k));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ready_out = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    ready_out = 1'b0;
    send(MUL_OP_MUL, rnd_vec(), rnd_vec(), 8'hE0);
    send(MUL_OP_MULH, rnd_vec(), rnd_vec(), 8'hE1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || result_out !== '0 || tag_out !== '0) begin
      fails++;
      $display("FAIL reset_midflight: valid=%b busy=%b res=%h tag=%h, expected all 0",
               valid_out, busy, result_out, tag_out);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    ready_out = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #2;
      if (valid_out !== 1'b0 || busy !== 1'b0) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++;
      $display("FAIL reset_no_stale: %0d cycles with valid_out/busy high, expected 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_high_variants();
    test_backpressure();
    test_bubble_collapse();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/rv_mul_pipeline.md
Name: rv_mul_pipeline

Overview:
- Multi-lane, latency-parametrised integer multiply unit for the ALU execute stage.
- Implements all four RV32M multiply variants (MUL, MULH, MULHSU, MULHU), selected per request.
- Elastic valid/ready pipeline: stalled stages hold, and bubbles collapse when downstream stalls.
- Carries an opaque tag (warp/wid/rd info) alongside each request.

Parameters:
- LANES, 4, number of parallel SIMT lanes sharing one op/tag.
- WIDTH, 32, operand and result width per lane.
- LATENCY, 3, pipeline stages (>=1); cycles from accept to valid_out when unstalled.
- TAGW, 8, tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  request valid.
- ready_in  out  1  unit can accept a request this cycle.
- op_in  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- dataa_in  in  LANES*WIDTH  rs1 operands, lane 0 at LSBs.
- datab_in  in  LANES*WIDTH  rs2 operands, lane 0 at LSBs.
- tag_in  in  TAGW  request tag.
- valid_out  out  1  result valid.
- ready_out  in  1  consumer accepts result.
- result_out  out  LANES*WIDTH  per-lane results.
- tag_out  out  TAGW  tag of the result.
- busy  out  1  any stage holds a valid entry.

Behaviour:
- Reset (reset low, async) clears all stage valid bits and stage data/tag registers. valid_out=0, result_out=0, tag_out=0, busy=0, ready_in=1.
- Any in-flight requests are discarded on reset; there is no replay.
- Stage k (0..LATENCY-1) holds v[k], data[k], tag[k]. Stage LATENCY-1 drives the outputs directly.
- Last-stage advance: adv[L-1] = !v[L-1] | ready_out.
- Other stages: adv[k] = !v[k] | adv[k+1]. Chain is combinational; no skid buffer.
- ready_in = adv[0]. A request is accepted when valid_in & ready_in.
- On adv[k]: v[k] <= v[k-1] (v[-1] = accept), and data/tag load from the previous stage. Without adv[k], the stage holds.
- Handshake rules:
  - valid_out/result_out/tag_out stay stable while valid_out & !ready_out.
  - Producer must hold inputs while valid_in & !ready_in.
- Throughput and latency:
  - One request per cycle under continuous ready_out.
  - Unstalled latency is exactly LATENCY cycles: accepted at edge t, valid_out high after edge t+LATENCY-1.
- Simultaneous accept and output pop in the same cycle at full occupancy is legal and sustains full throughput.
- Arithmetic, per lane, computed in stage 0 from registered-free inputs:
  - a_ext = {sign(a) if op in {MULH, MULHSU} else 0, a}.
  - b_ext = {sign(b) if op == MULH else 0, b}.
  - p = signed (WIDTH+1) x (WIDTH+1) product, keeping 2*WIDTH bits.
  - MUL selects p[WIDTH-1:0]; the other ops select p[2W-1:W].
- Result selection happens at the product stage. Only WIDTH bits per lane propagate through the remaining stages.
- busy = OR of v[]. Asserted the cycle after the first accept; deasserts when the last entry pops.
- No overflow or exception flags; results wrap per the RISC-V spec.

Decomposition:
- Shared package (ALU defines):
  - Op encodings MUL_OP_MUL/MULH/MULHSU/MULHU.
  - MUL_OP_BITS=2.
- Sub-module rv_mul_lane: one WIDTH-bit lane doing extension, product and high/low select (combinational), instantiated LANES times in stage 0.
- The elastic pipeline register chain is generated in the top module.

Test Plan:
- Reset mid-flight: 2 requests in flight, reset low one cycle -> valid_out=0 and busy=0 immediately; no stale result ever appears after release.
- MUL, a=0xFFFFFFFF, b=0xFFFFFFFF, ready_out=1 -> after exactly LATENCY cycles valid_out=1, result=0x00000001 in every lane, tag matches.
- High variants, a=0xFFFFFFFF, b=0xFFFFFFFF, one per lane/op:
  - MULH -> 0x00000000
  - MULHSU -> 0xFFFFFFFF
  - MULHU -> 0xFFFFFFFE
- Corner operands: a=0x80000000, b=0x80000000:
  - MULH -> 0x40000000
  - MUL -> 0x00000000
- Backpressure: stream 8 tagged requests (tags 0..7) with ready_out low for 5 cycles midway:
  - ready_in drops only once all LATENCY stages are full.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order with no loss or duplication.
- Bubble collapse: one request, ready_out=0, then a second request LATENCY cycles later -> the second is accepted and advances to stage LATENCY-2 behind the stalled first. With ready_out=1 the two pop on consecutive cycles.
